// File: rtl/ifetch_unit_if.sv
// Instruction bus interface for ifetch_unit.
// Fixed latency 1: rdata in cycle t+1 is the word at the araddr driven in cycle t.
interface ibus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [DATA_WIDTH-1:0] rdata;

  modport mgr (output araddr, input rdata);
  modport sub (input araddr, output rdata);
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit. It issues word addresses on a fixed-latency-1 bus,
// buffers the responses in a small FIFO and hands {inst, pc} to decode with
// a valid/ready handshake. A fetch is issued only when a FIFO slot is
// guaranteed free, counting the response still in flight. A redirect flushes
// the FIFO, drops the response arriving that cycle and restarts at the target.
// Optional macro IFETCH_UNIT_PERF_EN adds perf_fetch_cnt_o, a 32-bit count of
// accepted instructions.
module ifetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ibus_if.mgr                   ibus,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] pc_o
`ifdef IFETCH_UNIT_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] rpc_q;
  logic                  req_q;
  logic [CNT_W-1:0]      count_q;
  logic [PTR_W-1:0]      wptr_q;
  logic [PTR_W-1:0]      rptr_q;
  logic [DATA_WIDTH-1:0] mem_inst [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc   [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [CNT_W:0]        occupancy;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [1:0]            target_lsb_unused;

  // Word-aligned redirect target; the low two address bits are ignored.
  assign target            = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign target_lsb_unused = redirect_pc_i[1:0];

  assign pop  = inst_valid_o & inst_ready_i;
  assign push = req_q & ~redirect_i;

  // Issue decision: occupancy after this cycle, counting the in-flight response.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, req_q} - {{CNT_W{1'b0}}, pop};
    issue     = redirect_i | (occupancy < DEPTH_C);
    araddr    = redirect_i ? target : pc_q;
  end

  assign ibus.araddr = araddr;

  // Fetch PC, in-flight request flag and the address of the in-flight request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q  <= RESET_PC;
      req_q <= 1'b0;
      rpc_q <= '0;
    end else begin
      req_q <= issue;
      rpc_q <= araddr;
      if (issue) pc_q <= araddr + ADDR_WIDTH'(4);
    end
  end

  // FIFO occupancy and pointers; a redirect empties the buffer outright.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else if (redirect_i) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage, written with the response and the address it belongs to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (push) begin
      mem_inst[wptr_q] <= ibus.rdata;
      mem_pc[wptr_q]   <= rpc_q;
    end
  end

  assign inst_valid_o = (count_q != '0);
  assign inst_o       = mem_inst[rptr_q];
  assign pc_o         = mem_pc[rptr_q];

`ifdef IFETCH_UNIT_PERF_EN
  logic [31:0] perf_cnt_q;

  // Accepted-instruction counter; free-running, wraps at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  perf_cnt_q <= '0;
    else if (pop) perf_cnt_q <= perf_cnt_q + 32'd1;
  end

  assign perf_fetch_cnt_o = perf_cnt_q;
`else
  // No performance counter in this build.
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit. The bus model returns ~araddr one cycle
// later, so every accepted instruction must equal ~pc_o.
module tb_ifetch_unit;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
`ifdef IFETCH_UNIT_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  ibus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ifetch_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .ibus          (bus),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o)
`ifdef IFETCH_UNIT_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch_cnt_o)
`endif
  );

  // Latency-1 memory model.
  always @(posedge clk_i) begin
    if (!rst_ni) bus.rdata <= '0;
    else         bus.rdata <= ~bus.araddr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_empty(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every handshake pops the next expected PC.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && inst_valid_o === 1'b1 && inst_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_inst: got pc 0x%08h, want no instruction", pc_o);
      end else begin
        logic [31:0] p;
        p = exp_q.pop_front();
        check("pop_pc", pc_o, p);
        check("pop_inst", inst_o, ~p);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Reset with checks of the reset-state outputs; returns in cycle 0.
  task automatic do_reset();
    rst_ni     = 1'b0;
    redirect_i = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_araddr", bus.araddr, 32'd0);
`ifdef IFETCH_UNIT_PERF_EN
    check("rst_perf", perf_fetch_cnt_o, 32'd0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] tgt, input logic [31:0] exp_araddr, input int n);
    redirect_i    = 1'b1;
    redirect_pc_i = tgt;
    inst_ready_i  = 1'b0;
    exp_q.delete();
    push_seq(exp_araddr, n);
    #1;
    check("redir_araddr", bus.araddr, exp_araddr);
    tick();
    redirect_i   = 1'b0;
    inst_ready_i = 1'b1;
    check("redir_valid_next", {31'd0, inst_valid_o}, 32'd0);
    tick();
    check("redir_first_valid", {31'd0, inst_valid_o}, 32'd1);
    check("redir_first_pc", pc_o, exp_araddr);
    repeat (n) tick();
    inst_ready_i = 1'b0;
    check_empty("redir_drain");
  endtask

  initial begin
    rst_ni        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    inst_ready_i  = 1'b1;

    // Reset release with ready held high: one instruction per cycle.
    do_reset();
    push_seq(32'h0, 8);
    check("c0_araddr", bus.araddr, 32'h0);
    tick();
    check("c1_araddr", bus.araddr, 32'h4);
    check("c1_valid", {31'd0, inst_valid_o}, 32'd0);
    tick();
    check("c2_araddr", bus.araddr, 32'h8);
    check("c2_valid", {31'd0, inst_valid_o}, 32'd1);
    check("c2_pc", pc_o, 32'h0);
    tick();
    check("c3_araddr", bus.araddr, 32'hC);
    repeat (7) tick();
    inst_ready_i = 1'b0;
    check_empty("stream_drain");

    // Mid-operation reset discards buffered instructions at once.
    repeat (2) tick();
    rst_ni = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("async_rst_pc", pc_o, 32'd0);
    check("async_rst_inst", inst_o, 32'd0);

    // Back-pressure right from the first valid instruction.
    inst_ready_i = 1'b0;
    do_reset();
    push_seq(32'h0, 6);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, inst_valid_o}, 32'd1);
      check("stall_pc", pc_o, 32'h0);
      check("stall_araddr", bus.araddr, 32'h8);
      if (i < 4) tick();
    end
    tick();
    inst_ready_i = 1'b1;
    repeat (6) tick();
    inst_ready_i = 1'b0;
    check_empty("stall_drain");

    // Redirect with a full FIFO.
    repeat (3) tick();
    check("full_valid", {31'd0, inst_valid_o}, 32'd1);
    redirect_to(32'h100, 32'h100, 3);

    // Unaligned target is word-aligned.
    repeat (2) tick();
    redirect_to(32'h103, 32'h100, 2);

    // Address wrap at the top of the space.
    repeat (2) tick();
    redirect_to(32'hFFFF_FFFC, 32'hFFFF_FFFC, 3);

`ifdef IFETCH_UNIT_PERF_EN
    // Ten handshakes around one redirect; the counter ignores the redirect.
    inst_ready_i = 1'b1;
    do_reset();
    push_seq(32'h0, 5);
    repeat (7) tick();
    check_empty("perf_first_drain");
    redirect_to(32'h200, 32'h200, 5);
    check("perf_cnt", perf_fetch_cnt_o, 32'd10);
    rst_ni = 1'b0;
    #1;
    check("perf_rst", perf_fetch_cnt_o, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, instruction address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, fetch buffer entries; power of two, >=2.
REQ-005 SHALL use a single clock and an asynchronous, active-low reset, with ports as in REQ-006 and REQ-007.
REQ-006 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-007 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-008 SHALL have port ibus  ibus_if.mgr  ADDR/DATA_WIDTH  instruction bus manager; drives araddr, samples rdata.
REQ-009 SHALL have port redirect_i  input  1  flush and restart fetch at redirect_pc_i.
REQ-010 SHALL have port redirect_pc_i  input  ADDR_WIDTH  redirect target.
REQ-011 SHALL have port inst_valid_o  output  1  inst_o/pc_o hold a valid instruction.
REQ-012 SHALL have port inst_ready_i  input  1  downstream decode accepts the instruction.
REQ-013 SHALL have port inst_o  output  DATA_WIDTH  fetched instruction word.
REQ-014 SHALL have port pc_o  output  ADDR_WIDTH  address of inst_o.

Function
REQ-015 SHALL treat the bus as fixed latency 1: rdata in cycle t+1 is the word at araddr driven in cycle t.
REQ-016 SHALL compute pop = inst_valid_o & inst_ready_i and issue = (count_q + req_q - pop) < FIFO_DEPTH, or issue = 1 when redirect_i.
REQ-017 SHALL drive araddr combinationally: redirect_pc_i when redirect_i, else pc_q.
REQ-018 SHALL force bits [1:0] of redirect_pc_i to 0 wherever it is used.
REQ-019 SHALL, on issue, load pc_q with araddr+4, modulo 2^ADDR_WIDTH (wraps to 0); otherwise hold pc_q.
REQ-020 SHALL register req_q <= issue and rpc_q <= araddr; when req_q=1 and redirect_i=0, push {rdata, rpc_q} into the FIFO.
REQ-021 SHALL assert inst_valid_o = (count_q != 0), with no bypass: fetch latency from araddr to inst_valid_o is 2 cycles.
REQ-022 SHALL present the FIFO head on inst_o/pc_o and hold them stable while inst_valid_o=1 and inst_ready_i=0.
REQ-023 SHALL allow push and pop in the same cycle, with count_q unchanged and pointers wrapping modulo FIFO_DEPTH.
REQ-024 SHALL never overflow; the credit rule of REQ-016 guarantees this, and a push into a full FIFO is a design error.
REQ-025 SHALL, on redirect_i, take priority over pop and push: clear the FIFO (count_q=0), drop the response arriving that cycle, and issue the target.
REQ-026 SHALL drive inst_valid_o=0 in the cycle after a redirect; the first target instruction is valid 2 cycles after redirect_i.
REQ-027 SHALL sustain 1 instruction/cycle when inst_ready_i is held 1 with FIFO_DEPTH=2.

Reset
REQ-028 SHALL, while rst_ni=0, clear pc_q=RESET_PC, req_q=0, count_q=0, pointers=0, FIFO storage=0 and rpc_q=0.
REQ-029 SHALL drive outputs during reset as inst_valid_o=0, inst_o=0, pc_o=0, araddr=RESET_PC.
REQ-030 SHALL issue RESET_PC in the first cycle after rst_ni rises, with inst_valid_o rising 2 cycles later.
REQ-031 SHALL, on reset asserted mid-operation, discard in-flight and buffered instructions immediately, asynchronously.

Configuration
REQ-032 SHALL, when macro IFETCH_UNIT_PERF_EN is defined, add output perf_fetch_cnt_o, 32 bits: pop count, reset 0, wraps at 2^32, unaffected by redirect.
REQ-033 SHALL, when IFETCH_UNIT_PERF_EN is undefined, omit perf_fetch_cnt_o and its counter, with all other behaviour identical.

Verification
REQ-034 SHALL cover reset release with RESET_PC=0x0 and ready=1 -> araddr 0x0,0x4,0x8...; inst_valid_o rises cycle 2 with pc_o=0x0, then one instruction per cycle.
REQ-035 SHALL cover ready=0 for 5 cycles after the first valid -> pc_o=0x0 held; count_q=2; araddr holds 0x8 with no issue; on ready=1 instructions resume 0x0,0x4,0x8 with no gap or duplicate.
REQ-036 SHALL cover redirect_i with redirect_pc_i=0x100 while the FIFO is full -> next cycle inst_valid_o=0; 2 cycles later pc_o=0x100; no old PC ever emitted.
REQ-037 SHALL cover redirect_pc_i=0x103 -> araddr=0x100, pc_o=0x100, then 0x104.
REQ-038 SHALL cover wrap: redirect to 2^32-4 -> pc_o=0xFFFFFFFC, then 0x0.
REQ-039 SHALL cover IFETCH_UNIT_PERF_EN defined: 10 handshakes with one redirect mid-stream -> perf_fetch_cnt_o=10; rst_ni=0 -> 0.
